parking_gate_arbiter: RTL and testbench
=======================================

Name: parking_gate_arbiter

Overview:
- Shares the single parking gate between an entry lane and an exit lane.
- Arbitrates the two lane requests and issues one-cycle entry/exit command pulses to the slot-manager FSM.
- Sequences the door-open and "full" indicator hold timers.
- Sits between the lane sensors/buttons and the slot manager; reads back the slot manager's capacity and spot map to decide grant vs reject.

Parameters:
- OPEN_CYCLES, 40_000_000, cycles door_open is held after the issue cycle (must be ≥1).
- FULL_CYCLES, 40_000_000, cycles full_flag is held after a rejected entry (must be ≥1).
- CNT_W, 27, hold-counter width; must hold max(OPEN_CYCLES, FULL_CYCLES).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- entry_req  in  1  entry lane request; level, held until entry_ack.
- exit_req  in  1  exit lane request; level, held until exit_ack.
- exit_slot  in  2  slot index of the exiting car; valid while exit_req=1.
- capacity_in  in  3  remaining capacity from the slot manager (0..4).
- spots_in  in  4  occupancy map from the slot manager (1 = occupied).
- entry_ack  out  1  one-cycle acknowledge to the entry lane.
- exit_ack  out  1  one-cycle acknowledge to the exit lane.
- entry_pulse  out  1  one-cycle "car enters" command to the slot manager.
- exit_pulse  out  1  one-cycle "car exits" command to the slot manager.
- exit_slot_out  out  2  latched slot index; valid with exit_pulse.
- door_open  out  1  gate open.
- full_flag  out  1  lot-full indicator.
- exit_reject  out  1  one-cycle pulse: exit requested for an empty slot.
- busy  out  1  1 whenever state ≠ IDLE.

Behaviour:
- Reset (async, active-low): state = IDLE; hold counter = 0; rr_last = ENTRY, so exit wins the first tie. Every output = 0.
- States: IDLE, ISSUE, HOLD_OPEN, HOLD_FULL.
- IDLE, arbitration: candidates are entry_req and exit_req.
  - Both high: grant the lane not granted last (rr_last); after reset, exit wins.
  - Only one high: grant it.
  - rr_last updates on every grant, including rejects.
- IDLE, exit granted:
  - spots_in[exit_slot]=0 → exit_ack=1 and exit_reject=1 for one cycle; stay IDLE; no door activity.
  - Otherwise → latch exit_slot into exit_slot_out; next state ISSUE(exit).
- IDLE, entry granted:
  - capacity_in=0 → entry_ack=1 for one cycle; next state HOLD_FULL; full_flag=1 from the next cycle.
  - Otherwise → next state ISSUE(entry).
- ISSUE (exactly 1 cycle):
  - Entry: entry_pulse=1 and entry_ack=1. Exit: exit_pulse=1 and exit_ack=1.
  - door_open=1; counter cleared; next state HOLD_OPEN.
- HOLD_OPEN: door_open=1; counter increments each cycle; after OPEN_CYCLES cycles → IDLE with door_open=0 in the IDLE cycle.
  - Total door_open high time = OPEN_CYCLES+1 cycles.
- HOLD_FULL: full_flag=1 for FULL_CYCLES cycles (first cycle included), then → IDLE with full_flag=0.
- Latency: request seen in IDLE at cycle t → command pulse and ack at t+1. Reject paths: ack at t (exit reject), or ack at t with full_flag at t+1 (entry full).
- Requests arriving while busy are neither dropped nor acked. They are evaluated on the first IDLE cycle.
- A request still high in the cycle after its ack is treated as a new request. Requesters must drop the request after ack.
- At most one of entry_pulse/exit_pulse is high in any cycle; never both.
- Stale-value rule: capacity_in and spots_in are sampled only in IDLE. The slot manager updates one cycle after a pulse; the hold states guarantee IDLE never sees a stale value.
- Reset asserted mid-operation: immediate return to IDLE with all outputs 0. A pending pulse is not emitted.
- Counter compare is unsigned; it never wraps within CNT_W.

Test Plan:
All scenarios use OPEN_CYCLES=4, FULL_CYCLES=3.

1. Reset, then entry_req=1 at cycle 0 with capacity_in=4.
   - Cycle 1: entry_pulse=1, entry_ack=1, door_open=1.
   - door_open high in cycles 1–5, 0 at cycle 6; busy mirrors this.
2. entry_req and exit_req both rise in the same cycle, exit_slot=2, spots_in=0100, capacity_in=3.
   - Exit is issued first: exit_pulse=1, exit_slot_out=2.
   - Entry is issued at the first IDLE cycle after the door closes (cycle 7).
   - Repeat the tie → entry wins this time (round-robin).
3. entry_req with capacity_in=0.
   - entry_ack at cycle 0; full_flag=1 in cycles 1–3; no entry_pulse; door_open stays 0.
4. exit_req, exit_slot=1, spots_in=0001.
   - Same cycle: exit_ack=1 and exit_reject=1; no exit_pulse, no door; busy stays 0.
5. exit_req raised while in HOLD_OPEN.
   - No ack during the hold; serviced with a one-cycle exit_pulse on the cycle after IDLE is re-entered.
6. Reset pulled low during HOLD_OPEN at counter=2.
   - door_open, busy and all pulses drop asynchronously.
   - After release, a new entry_req is granted with exit-first priority restored.

Source files
------------

// File: rtl/parking_gate_arbiter.sv
// -----------------------------------------------------------------------------
// parking_gate_arbiter
//
// Shares the single parking gate between the entry lane and the exit lane.
// Arbitrates the two lane requests round-robin, decides grant vs reject using
// the slot manager's capacity and spot map, issues one-cycle entry/exit
// command pulses to the slot manager, and times the door-open and lot-full
// indicator holds.
//
// Handshake: entry_req / exit_req are levels held by the lane until the
// matching one-cycle ack. A request that is still high in the cycle after its
// ack is treated as a new request. Requests seen while busy are neither
// dropped nor acked; they are evaluated on the first IDLE cycle.
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous, active-low reset
//   entry_req      entry lane request (level)
//   exit_req       exit lane request (level)
//   exit_slot      slot index of the exiting car, valid with exit_req
//   capacity_in    remaining capacity from the slot manager (0..4)
//   spots_in       occupancy map from the slot manager (1 = occupied)
//   entry_ack      one-cycle acknowledge to the entry lane
//   exit_ack       one-cycle acknowledge to the exit lane
//   entry_pulse    one-cycle "car enters" command
//   exit_pulse     one-cycle "car exits" command
//   exit_slot_out  latched slot index, valid with exit_pulse
//   door_open      gate open
//   full_flag      lot-full indicator
//   exit_reject    one-cycle pulse: exit requested for an empty slot
//   busy           high whenever the FSM is not in IDLE
//   state_dbg      current FSM state (IDLE=0, ISSUE=1, HOLD_OPEN=2, HOLD_FULL=3)
// -----------------------------------------------------------------------------
module parking_gate_arbiter #(
  parameter int unsigned OPEN_CYCLES = 40_000_000,
  parameter int unsigned FULL_CYCLES = 40_000_000,
  parameter int          CNT_W       = 27
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       entry_req,
  input  logic       exit_req,
  input  logic [1:0] exit_slot,
  input  logic [2:0] capacity_in,
  input  logic [3:0] spots_in,
  output logic       entry_ack,
  output logic       exit_ack,
  output logic       entry_pulse,
  output logic       exit_pulse,
  output logic [1:0] exit_slot_out,
  output logic       door_open,
  output logic       full_flag,
  output logic       exit_reject,
  output logic       busy,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    HOLD_OPEN = 2'd2,
    HOLD_FULL = 2'd3
  } state_t;

  // Hold counters count 0..N-1, so the terminal value is N-1.
  localparam logic [CNT_W-1:0] OPEN_LAST = CNT_W'(OPEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(FULL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state, state_nxt;
  logic             rr_exit_last, rr_exit_last_nxt; // 1: exit lane granted last
  logic             issue_exit, issue_exit_nxt;     // direction of pending ISSUE
  logic [1:0]       slot_q, slot_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic grant_exit, grant_entry;
  logic entry_ack_c, exit_ack_c, entry_pulse_c, exit_pulse_c, exit_reject_c;

  // On a tie the lane that was not granted last wins; reset leaves
  // rr_exit_last=0 so exit wins the first tie.
  assign grant_exit  = exit_req & (~entry_req | ~rr_exit_last);
  assign grant_entry = entry_req & ~grant_exit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      rr_exit_last <= 1'b0;
      issue_exit   <= 1'b0;
      slot_q       <= 2'd0;
      cnt          <= '0;
    end else begin
      state        <= state_nxt;
      rr_exit_last <= rr_exit_last_nxt;
      issue_exit   <= issue_exit_nxt;
      slot_q       <= slot_nxt;
      cnt          <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    rr_exit_last_nxt = rr_exit_last;
    issue_exit_nxt   = issue_exit;
    slot_nxt         = slot_q;
    cnt_nxt          = '0;
    entry_ack_c      = 1'b0;
    exit_ack_c       = 1'b0;
    entry_pulse_c    = 1'b0;
    exit_pulse_c     = 1'b0;
    exit_reject_c    = 1'b0;

    case (state)
      IDLE: begin
        // capacity_in / spots_in are only consulted here; the hold states
        // give the slot manager time to update after a pulse.
        if (grant_exit) begin
          rr_exit_last_nxt = 1'b1;
          if (!spots_in[exit_slot]) begin
            exit_ack_c    = 1'b1;
            exit_reject_c = 1'b1;
          end else begin
            slot_nxt       = exit_slot;
            issue_exit_nxt = 1'b1;
            state_nxt      = ISSUE;
          end
        end else if (grant_entry) begin
          rr_exit_last_nxt = 1'b0;
          if (capacity_in == 3'd0) begin
            entry_ack_c = 1'b1;
            state_nxt   = HOLD_FULL;
          end else begin
            issue_exit_nxt = 1'b0;
            state_nxt      = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (issue_exit) begin
          exit_pulse_c = 1'b1;
          exit_ack_c   = 1'b1;
        end else begin
          entry_pulse_c = 1'b1;
          entry_ack_c   = 1'b1;
        end
        state_nxt = HOLD_OPEN;
      end
      HOLD_OPEN: begin
        if (cnt == OPEN_LAST) state_nxt = IDLE;
        else                  cnt_nxt   = cnt + CNT_ONE;
      end
      HOLD_FULL: begin
        if (cnt == FULL_LAST) state_nxt = IDLE;
        else                  cnt_nxt   = cnt + CNT_ONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The IDLE-cycle acks depend on live inputs, so they are masked by reset
  // to keep every output low while reset is held.
  assign entry_ack     = entry_ack_c & reset;
  assign exit_ack      = exit_ack_c & reset;
  assign entry_pulse   = entry_pulse_c & reset;
  assign exit_pulse    = exit_pulse_c & reset;
  assign exit_reject   = exit_reject_c & reset;
  assign exit_slot_out = slot_q;
  assign door_open     = (state == ISSUE) || (state == HOLD_OPEN);
  assign full_flag     = (state == HOLD_FULL);
  assign busy          = (state != IDLE);
  assign state_dbg     = state;

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// -----------------------------------------------------------------------------
// tb_parking_gate_arbiter
//
// Directed bench for parking_gate_arbiter with OPEN_CYCLES=4, FULL_CYCLES=3.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 time
// unit later, well before the next rising edge. Output bundle bit order:
//   [7] entry_ack [6] exit_ack [5] entry_pulse [4] exit_pulse
//   [3] door_open [2] full_flag [1] exit_reject [0] busy
// -----------------------------------------------------------------------------
module tb_parking_gate_arbiter;

  logic       clk;
  logic       reset;
  logic       entry_req;
  logic       exit_req;
  logic [1:0] exit_slot;
  logic [2:0] capacity_in;
  logic [3:0] spots_in;
  logic       entry_ack;
  logic       exit_ack;
  logic       entry_pulse;
  logic       exit_pulse;
  logic [1:0] exit_slot_out;
  logic       door_open;
  logic       full_flag;
  logic       exit_reject;
  logic       busy;
  logic [1:0] state_dbg;

  logic [7:0] outs;
  int         checks;
  int         failures;

  assign outs = {entry_ack, exit_ack, entry_pulse, exit_pulse,
                 door_open, full_flag, exit_reject, busy};

  parking_gate_arbiter #(
    .OPEN_CYCLES(4),
    .FULL_CYCLES(3),
    .CNT_W(27)
  ) dut (
    .clk(clk),
    .reset(reset),
    .entry_req(entry_req),
    .exit_req(exit_req),
    .exit_slot(exit_slot),
    .capacity_in(capacity_in),
    .spots_in(spots_in),
    .entry_ack(entry_ack),
    .exit_ack(exit_ack),
    .entry_pulse(entry_pulse),
    .exit_pulse(exit_pulse),
    .exit_slot_out(exit_slot_out),
    .door_open(door_open),
    .full_flag(full_flag),
    .exit_reject(exit_reject),
    .busy(busy),
    .state_dbg(state_dbg)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    reset       = 1'b0;
    entry_req   = 1'b0;
    exit_req    = 1'b0;
    exit_slot   = 2'd0;
    capacity_in = 3'd4;
    spots_in    = 4'b0000;

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    chk("reset_outs", outs, 8'h00);
    chk("reset_state", {6'd0, state_dbg}, 8'd0);
    chk("reset_slot", {6'd0, exit_slot_out}, 8'd0);
    reset = 1'b1;

    // S1: plain entry, door held OPEN_CYCLES+1 cycles
    next_cycle(); entry_req = 1'b1; capacity_in = 3'd4; #1;
    chk("s1_c0", outs, 8'h00);
    next_cycle(); entry_req = 1'b0; #1;
    chk("s1_c1_issue", outs, 8'hA9);
    chk("s1_c1_state", {6'd0, state_dbg}, 8'd1);
    for (int c = 2; c <= 5; c++) begin
      next_cycle(); #1;
      chk($sformatf("s1_hold_c%0d", c), outs, 8'h09);
    end
    next_cycle(); #1;
    chk("s1_c6_idle", outs, 8'h00);

    // S2: tie after reset -> exit first, entry serviced after the hold
    next_cycle();
    entry_req = 1'b1; exit_req = 1'b1; exit_slot = 2'd2;
    spots_in = 4'b0100; capacity_in = 3'd3; #1;
    chk("s2_c0", outs, 8'h00);
    next_cycle(); exit_req = 1'b0; #1;
    chk("s2_c1_exit", outs, 8'h59);
    chk("s2_c1_slot", {6'd0, exit_slot_out}, 8'd2);
    for (int c = 2; c <= 5; c++) begin
      next_cycle(); #1;
      chk($sformatf("s2_hold_c%0d", c), outs, 8'h09);
    end
    next_cycle(); #1;
    chk("s2_c6_idle", outs, 8'h00);
    next_cycle(); entry_req = 1'b0; #1;
    chk("s2_c7_entry", outs, 8'hA9);
    repeat (4) next_cycle();
    next_cycle(); #1;
    chk("s2_c12_idle", outs, 8'h00);

    // S3: entry with no capacity -> ack now, full_flag for 3 cycles
    next_cycle(); entry_req = 1'b1; capacity_in = 3'd0; #1;
    chk("s3_c0_ack", outs, 8'h80);
    next_cycle(); entry_req = 1'b0; #1;
    chk("s3_c1_full", outs, 8'h05);
    next_cycle(); #1;
    chk("s3_c2_full", outs, 8'h05);
    next_cycle(); #1;
    chk("s3_c3_full", outs, 8'h05);
    next_cycle(); #1;
    chk("s3_c4_idle", outs, 8'h00);

    // S4: exit for an empty slot -> same-cycle reject, no door
    next_cycle(); exit_req = 1'b1; exit_slot = 2'd1; spots_in = 4'b0001; #1;
    chk("s4_c0_reject", outs, 8'h42);
    next_cycle(); exit_req = 1'b0; #1;
    chk("s4_c1_idle", outs, 8'h00);

    // S2b: exit was granted last (reject) -> entry wins the tie,
    // and the held exit is serviced after the door closes
    next_cycle();
    entry_req = 1'b1; exit_req = 1'b1; exit_slot = 2'd2;
    spots_in = 4'b0100; capacity_in = 3'd2; #1;
    chk("s2b_c0", outs, 8'h00);
    next_cycle(); entry_req = 1'b0; #1;
    chk("s2b_c1_entry", outs, 8'hA9);
    for (int c = 2; c <= 5; c++) begin
      next_cycle(); #1;
      chk($sformatf("s2b_hold_c%0d", c), outs, 8'h09);
    end
    next_cycle(); #1;
    chk("s2b_c6_idle", outs, 8'h00);
    next_cycle(); exit_req = 1'b0; #1;
    chk("s2b_c7_exit", outs, 8'h59);
    chk("s2b_c7_slot", {6'd0, exit_slot_out}, 8'd2);
    repeat (4) next_cycle();
    next_cycle(); #1;
    chk("s2b_c12_idle", outs, 8'h00);

    // S5: exit raised during HOLD_OPEN is held off, then serviced
    next_cycle(); entry_req = 1'b1; capacity_in = 3'd3; #1;
    chk("s5_c0", outs, 8'h00);
    next_cycle(); entry_req = 1'b0; #1;
    chk("s5_c1_entry", outs, 8'hA9);
    next_cycle(); #1;
    chk("s5_c2_hold", outs, 8'h09);
    next_cycle(); exit_req = 1'b1; exit_slot = 2'd3; spots_in = 4'b1000; #1;
    chk("s5_c3_hold", outs, 8'h09);
    next_cycle(); #1;
    chk("s5_c4_hold", outs, 8'h09);
    next_cycle(); #1;
    chk("s5_c5_hold", outs, 8'h09);
    next_cycle(); #1;
    chk("s5_c6_idle", outs, 8'h00);
    next_cycle(); exit_req = 1'b0; #1;
    chk("s5_c7_exit", outs, 8'h59);
    chk("s5_c7_slot", {6'd0, exit_slot_out}, 8'd3);
    repeat (4) next_cycle();
    next_cycle(); #1;
    chk("s5_c12_idle", outs, 8'h00);

    // S6: reset during HOLD_OPEN (counter=2), then exit-first restored
    next_cycle(); entry_req = 1'b1; capacity_in = 3'd4; #1;
    next_cycle(); entry_req = 1'b0; #1;
    chk("s6_c1_entry", outs, 8'hA9);
    next_cycle(); #1;
    next_cycle(); #1;
    next_cycle(); #1;
    chk("s6_c4_hold", outs, 8'h09);
    reset = 1'b0; #1;
    chk("s6_rst_outs", outs, 8'h00);
    chk("s6_rst_state", {6'd0, state_dbg}, 8'd0);
    chk("s6_rst_slot", {6'd0, exit_slot_out}, 8'd0);
    next_cycle(); reset = 1'b1; #1;
    chk("s6_released", outs, 8'h00);
    next_cycle();
    entry_req = 1'b1; exit_req = 1'b1; exit_slot = 2'd3;
    spots_in = 4'b1000; capacity_in = 3'd4; #1;
    chk("s6_tie_c0", outs, 8'h00);
    next_cycle(); exit_req = 1'b0; #1;
    chk("s6_tie_exit", outs, 8'h59);
    chk("s6_tie_slot", {6'd0, exit_slot_out}, 8'd3);
    repeat (4) next_cycle();
    next_cycle(); #1;
    chk("s6_c6_idle", outs, 8'h00);
    next_cycle(); entry_req = 1'b0; #1;
    chk("s6_c7_entry", outs, 8'hA9);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
